predictor_client: RTL and testbench

- Requester/trainer side of the 2-bit branch predictor interface (request/result/taken/prediction).
- Buffers actual branch outcomes from the execute stage and queries the predictor for each branch.
- Captures the predictor's prediction, trains the predictor with the real outcome, and keeps accuracy statistics.
- Sits between the execute/trace source and the predictor instance.

---
 rtl/pred_pkg.sv | 34 +++
 rtl/predictor_client_if.sv | 32 +++
 rtl/outcome_fifo.sv | 51 +++++
 rtl/predictor_client.sv | 132 +++++++++++++
 tb/tb_predictor_client.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pred_pkg.sv
// Shared definitions for the predictor client, the predictor and its bench model.
// Holds the client FSM state enum, the 2-bit predictor state encodings and a training helper.
// No ports; imported with import pred_pkg::*.
package pred_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUERY   = 2'd1,
        CAPTURE = 2'd2,
        TRAIN   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } pred_state_t;

    // Next state of a 2-bit saturating predictor trained with outcome tk.
    function automatic pred_state_t pred_train(pred_state_t s, logic tk);
        pred_state_t n;
        n = SNT;
        case (s)
            SNT: n = tk ? WNT : SNT;
            WNT: n = tk ? WT  : SNT;
            WT:  n = tk ? ST  : WNT;
            ST:  n = tk ? ST  : WT;
            default: n = SNT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/predictor_client_if.sv
// Bundles the outcome push channel, the predictor query/train strobes and the statistics.
// master modport = predictor_client side; slave modport = trace source / predictor / observer side.
// Ports: none (signals only); CNT_W sets the statistics counter width.
interface predictor_client_if #(
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_taken;
    logic             in_ready;
    logic             prediction;
    logic             result;
    logic             request;
    logic             taken;
    logic             busy;
    logic             upd_valid;
    logic             upd_correct;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] miss_count;
    logic             clr_stats;

    modport master (
        input  in_valid, in_taken, prediction, clr_stats,
        output in_ready, result, request, taken, busy,
               upd_valid, upd_correct, branch_count, miss_count
    );

    modport slave (
        output in_valid, in_taken, prediction, clr_stats,
        input  in_ready, result, request, taken, busy,
               upd_valid, upd_correct, branch_count, miss_count
    );
endinterface

// File: rtl/outcome_fifo.sv
// Purpose: DEPTH x 1-bit synchronous FIFO holding branch outcomes, with full/empty/count.
// Latency: written data is visible at rd_data the cycle after the push when the FIFO was empty.
// Backpressure: full is the caller's ready; a push while full or a pop while empty is ignored.
// Ports: clk, rst (async, active high), wr_en/wr_data, rd_en/rd_data (head), full, empty, count.
module outcome_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       wr_data,
    input  logic                       rd_en,
    output logic                       rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Pointers wrap naturally because DEPTH is a power of two.
            count <= count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
        end
    end
endmodule

// File: rtl/predictor_client.sv
// Purpose: queues branch outcomes, queries the 2-bit predictor per branch, trains it and keeps hit/miss stats.
// Latency: query 1 cycle after a push into an idle, empty client; one branch retires every 3 cycles.
// Backpressure: in_ready = outcome FIFO not full (no look-ahead to a same-cycle pop); pushes while full are dropped.
// Ports: clk, rst (async, active high), bus (predictor_client_if.master): push channel, predictor
//        strobes result/request/taken with prediction input, busy, upd_valid/upd_correct, counters, clr_stats.
module predictor_client
    import pred_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    predictor_client_if.master    bus
);
    state_t                 state;
    logic                   result_q;
    logic                   request_q;
    logic                   taken_q;
    logic                   pred_q;
    logic                   upd_valid_q;
    logic                   upd_correct_q;
    logic [CNT_W-1:0]       branch_q;
    logic [CNT_W-1:0]       miss_q;

    logic                   head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   pop;
    logic                   miss;

    // The head is consumed on the edge that leaves TRAIN.
    assign pop  = (state == TRAIN);
    assign miss = (pred_q != head);

    outcome_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.in_valid),
        .wr_data (bus.in_taken),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Strobes are registered alongside the state so result and request can never overlap
    // and have no combinational path from any input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            result_q      <= 1'b0;
            request_q     <= 1'b0;
            taken_q       <= 1'b0;
            pred_q        <= 1'b0;
            upd_valid_q   <= 1'b0;
            upd_correct_q <= 1'b0;
        end else begin
            upd_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state    <= QUERY;
                        result_q <= 1'b1;
                    end
                end
                QUERY: begin
                    state    <= CAPTURE;
                    result_q <= 1'b0;
                end
                CAPTURE: begin
                    // Predictor answers the cycle after the query strobe.
                    state     <= TRAIN;
                    pred_q    <= bus.prediction;
                    request_q <= 1'b1;
                    taken_q   <= head;
                end
                TRAIN: begin
                    request_q     <= 1'b0;
                    taken_q       <= 1'b0;
                    upd_valid_q   <= 1'b1;
                    upd_correct_q <= ~miss;
                    // Decide on the pre-pop count: more than one entry means work remains.
                    if (fifo_count > ($clog2(DEPTH)+1)'(1)) begin
                        state    <= QUERY;
                        result_q <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    result_q  <= 1'b0;
                    request_q <= 1'b0;
                    taken_q   <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics; a clear wins over a same-cycle retirement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_q <= '0;
            miss_q   <= '0;
        end else if (bus.clr_stats) begin
            branch_q <= '0;
            miss_q   <= '0;
        end else if (state == TRAIN) begin
            if (branch_q != '1) begin
                branch_q <= branch_q + CNT_W'(1);
            end
            if (miss && (miss_q != '1)) begin
                miss_q <= miss_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready     = ~fifo_full;
    assign bus.result       = result_q;
    assign bus.request      = request_q;
    assign bus.taken        = taken_q;
    assign bus.busy         = (state != IDLE) | ~fifo_empty;
    assign bus.upd_valid    = upd_valid_q;
    assign bus.upd_correct  = upd_correct_q;
    assign bus.branch_count = branch_q;
    assign bus.miss_count   = miss_q;
endmodule

// File: tb/tb_predictor_client.sv
// Bench for predictor_client: drives outcomes, emulates the 2-bit predictor, and compares every
// output each cycle against a queue/countdown reference model. Counters are built 8 bits wide
// so saturation is reached in a short run.
module tb_predictor_client;
    import pred_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = 8;
    localparam int MAXC  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    predictor_client_if #(.CNT_W(CW)) bus ();

    predictor_client #(
        .DEPTH (DEPTH),
        .CNT_W (CW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state.
    bit          mq[$];     // outcomes accepted but not yet retired
    int          left;      // edges until the in-flight branch retires (0 = nothing in flight)
    int          ref_ctr;   // predictor counter 0..3 as seen by the reference
    int          bc;
    int          mc;
    // Emulated predictor attached to the DUT.
    pred_state_t env_ps;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    // One clock: advance the model with the inputs currently applied, clock the DUT,
    // respond as the predictor, then compare all outputs.
    task automatic step();
        logic r, q, t;
        int   pre;
        bit   retire, hd, exp_c;
        r = bus.result; q = bus.request; t = bus.taken;
        pre = mq.size(); retire = 0; hd = 0; exp_c = 0;
        if (left == 0) begin
            if (pre > 0) left = 3;
        end else begin
            left--;
            if (left == 0) begin
                retire = 1;
                hd = mq.pop_front();
                exp_c = ((ref_ctr >= 2) == hd);
                ref_ctr = hd ? ((ref_ctr < 3) ? ref_ctr + 1 : 3) : ((ref_ctr > 0) ? ref_ctr - 1 : 0);
                if (pre - 1 > 0) left = 3;
            end
        end
        if (bus.clr_stats) begin
            bc = 0; mc = 0;
        end else if (retire) begin
            if (bc < MAXC) bc++;
            if (!exp_c && mc < MAXC) mc++;
        end
        if (bus.in_valid && pre < DEPTH) mq.push_back(bus.in_taken);

        @(posedge clk); #1;

        if (r) bus.prediction = env_ps[1];
        else if (q) env_ps = pred_train(env_ps, t);

        chk("overlap", 32'(bus.result & bus.request), 32'(0));
        chk("result", 32'(bus.result), 32'(left == 3));
        chk("request", 32'(bus.request), 32'(left == 1));
        if (left == 1) chk("taken", 32'(bus.taken), 32'(mq[0]));
        chk("upd_valid", 32'(bus.upd_valid), 32'(retire));
        if (retire) chk("upd_correct", 32'(bus.upd_correct), 32'(exp_c));
        chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
        chk("busy", 32'(bus.busy), 32'(left != 0 || mq.size() != 0));
        chk("branch_count", 32'(bus.branch_count), 32'(bc));
        chk("miss_count", 32'(bus.miss_count), 32'(mc));
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((left != 0 || mq.size() != 0) && n < max) begin
            step();
            n++;
        end
        if (n >= max) chk("drain_busy", 32'(bus.busy), 32'(0));
    endtask

    task automatic push(input bit tk);
        bus.in_valid = 1'b1;
        bus.in_taken = tk;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(1));
        chk({tag, "_result"}, 32'(bus.result), 32'(0));
        chk({tag, "_request"}, 32'(bus.request), 32'(0));
        chk({tag, "_taken"}, 32'(bus.taken), 32'(0));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
        chk({tag, "_upd_valid"}, 32'(bus.upd_valid), 32'(0));
        chk({tag, "_upd_correct"}, 32'(bus.upd_correct), 32'(0));
        chk({tag, "_branch_count"}, 32'(bus.branch_count), 32'(0));
        chk({tag, "_miss_count"}, 32'(bus.miss_count), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_taken = 1'b0; bus.prediction = 1'b0; bus.clr_stats = 1'b0;
        env_ps = SNT; ref_ctr = 0; left = 0; bc = 0; mc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_checks("por");
        rst = 1'b0;

        // Fresh predictor, three taken branches: predictions 0,0,1.
        for (int i = 0; i < 3; i++) push(1'b1);
        drain(50);
        chk("ttt_branch_count", 32'(bus.branch_count), 32'(3));
        chk("ttt_miss_count", 32'(bus.miss_count), 32'(2));

        // Predictor at ST, four not-taken: predictions 1,1,0,0.
        for (int i = 0; i < 4; i++) push(1'b0);
        drain(50);
        chk("nnnn_branch_count", 32'(bus.branch_count), 32'(7));
        chk("nnnn_miss_count", 32'(bus.miss_count), 32'(4));
        chk("nnnn_pred_state", 32'(env_ps), 32'(SNT));

        // Hold in_valid high long enough to fill the FIFO and have pushes dropped.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_taken = 1'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
        drain(200);

        // Three queued, FSM in CAPTURE: reset mid-cycle.
        for (int i = 0; i < 3; i++) push(1'($urandom));
        #2;
        rst = 1'b1;
        #1;
        mq.delete(); left = 0; bc = 0; mc = 0;
        rst_checks("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        push(1'b1);
        step();
        chk("post_rst_query", 32'(bus.result), 32'(1));
        drain(50);

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.in_taken  = 1'($urandom);
            bus.clr_stats = ($urandom_range(0, 63) == 0);
            step();
        end
        bus.in_valid = 1'b0; bus.clr_stats = 1'b0;
        drain(200);

        // Saturation: every branch pushed against the current prediction.
        bus.clr_stats = 1'b1;
        step();
        bus.clr_stats = 1'b0;
        for (int i = 0; i < MAXC + 2; i++) begin
            push(ref_ctr < 2);
            drain(50);
        end
        chk("sat_branch_count", 32'(bus.branch_count), 32'(MAXC));
        chk("sat_miss_count", 32'(bus.miss_count), 32'(MAXC));

        // Clear coincident with a retirement.
        push(1'b1);
        for (int i = 0; i < 10 && left != 1; i++) step();
        bus.clr_stats = 1'b1;
        step();
        bus.clr_stats = 1'b0;
        chk("clr_branch_count", 32'(bus.branch_count), 32'(0));
        chk("clr_miss_count", 32'(bus.miss_count), 32'(0));
        drain(50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
